// File: rtl/mic_sample_sequencer_pkg.sv
// Shared definitions for the microphone sample sequencer.
// Contents: converter/PWM word widths, default slot length and the FSM state type.
package mic_sample_sequencer_pkg;

  localparam int unsigned ADC_BITS           = 12;
  localparam int unsigned PWM_BITS           = 11;
  // 100 MHz / 44.1 kHz, rounded.
  localparam int unsigned DEFAULT_SAMPLE_DIV = 2268;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitDone,
    StAccum,
    StOutput
  } state_t;

endpackage

// File: rtl/mic_sample_sequencer_moving_average.sv
// Power-of-two moving average over the last 2^AVG_LOG2 converter samples.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-low reset (clears ring, pointer and sum)
//   load - push din into the window this cycle
//   din  - new 12-bit sample
//   avg  - running sum divided by the window length
module mic_sample_sequencer_moving_average
  import mic_sample_sequencer_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic [ADC_BITS-1:0] din,
  output logic [ADC_BITS-1:0] avg
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  // Keep the pointer at least one bit wide; with a single-entry window it stays at 0.
  localparam int unsigned PW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned RING  = 1 << PW;
  localparam int unsigned SW    = ADC_BITS + AVG_LOG2;

  logic [ADC_BITS-1:0] ring [RING];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       wptr_nxt;
  logic [SW-1:0]       sum;

  always_comb begin
    wptr_nxt = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
  end

  // The slot under wptr holds the oldest sample, so it leaves the sum as din enters.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < RING; i++) begin
        ring[i] <= '0;
      end
      wptr <= '0;
      sum  <= '0;
    end else if (load) begin
      ring[wptr] <= din;
      wptr       <= wptr_nxt;
      sum        <= sum + SW'(din) - SW'(ring[wptr]);
    end
  end

  assign avg = ADC_BITS'(sum >> AVG_LOG2);

endmodule

// File: rtl/mic_sample_sequencer.sv
// Sample-rate pacing and smoothing around the SPI ADC receiver.
// Ports:
//   CLK          - clock, rising edge
//   RST          - synchronous active-low reset
//   ENABLE       - run the sample timer
//   SPI_START    - conversion request to the receiver (held until DONE or timeout)
//   SPI_DONE     - conversion complete from the receiver
//   SPI_VALUE    - conversion result, bits [11:0] used
//   PWM_DUTY     - smoothed sample, bits [11:1] of the window average
//   SAMPLE_VALID - one-cycle pulse when PWM_DUTY updates
//   OVERRUN      - sticky, a sample slot was dropped
//   TIMEOUT_ERR  - sticky, a conversion was abandoned
module mic_sample_sequencer
  import mic_sample_sequencer_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  output logic                SPI_START,
  input  logic                SPI_DONE,
  input  logic [15:0]         SPI_VALUE,
  output logic [PWM_BITS-1:0] PWM_DUTY,
  output logic                SAMPLE_VALID,
  output logic                OVERRUN,
  output logic                TIMEOUT_ERR
);

  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic [DW-1:0]       tick_cnt;
  logic [TW-1:0]       to_cnt;
  logic                tick;
  logic                pending;
  logic                leave_idle;
  logic                load;
  logic [ADC_BITS-1:0] sample;
  logic [ADC_BITS-1:0] avg;
  logic                unused_bits;

  assign unused_bits = ^{SPI_VALUE[15:12], avg[0]};

  assign tick       = ENABLE && (tick_cnt == DW'(SAMPLE_DIV - 1));
  // A DONE still high from the previous conversion must not be mistaken for completion.
  assign leave_idle = (state == StIdle) && pending && !SPI_DONE;
  assign load       = (state == StAccum);

  always_ff @(posedge CLK) begin
    if (!RST || !ENABLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A tick landing on the edge that consumes the queued one simply re-queues.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pending <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (tick) begin
      if (pending && !leave_idle) begin
        OVERRUN <= 1'b1;
      end else begin
        pending <= 1'b1;
      end
    end else if (leave_idle) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= StIdle;
      to_cnt       <= '0;
      sample       <= '0;
      SPI_START    <= 1'b0;
      PWM_DUTY     <= '0;
      SAMPLE_VALID <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      case (state)
        StIdle: begin
          if (leave_idle) begin
            state <= StReq;
          end
        end
        StReq: begin
          SPI_START <= 1'b1;
          to_cnt    <= '0;
          state     <= StWaitDone;
        end
        StWaitDone: begin
          // DONE takes priority over the timeout limit on the same cycle.
          if (SPI_DONE) begin
            sample    <= SPI_VALUE[ADC_BITS-1:0];
            SPI_START <= 1'b0;
            state     <= StAccum;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            TIMEOUT_ERR <= 1'b1;
            SPI_START   <= 1'b0;
            state       <= StIdle;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        StAccum: begin
          state <= StOutput;
        end
        StOutput: begin
          PWM_DUTY     <= avg[ADC_BITS-1:1];
          SAMPLE_VALID <= 1'b1;
          state        <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  mic_sample_sequencer_moving_average #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .CLK (CLK),
    .RST (RST),
    .load(load),
    .din (sample),
    .avg (avg)
  );

endmodule

// File: tb/tb_mic_sample_sequencer.sv
// Directed bench for mic_sample_sequencer. Three instances share one clock:
//   0: defaults (slot 2268, window 4, timeout 1024)
//   1: slot 64, window 1 (raw sample)
//   2: slot 1024, window 4, timeout 4096 (slow receiver / overrun)
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_mic_sample_sequencer;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  en;
  logic [2:0]  done;
  logic [15:0] val   [3];
  logic [2:0]  start;
  logic [2:0]  valid;
  logic [2:0]  ovr;
  logic [2:0]  terr;
  logic [10:0] duty  [3];

  int n_checks;
  int n_fail;
  int n;

  mic_sample_sequencer u_main (
    .CLK(clk), .RST(rst[0]), .ENABLE(en[0]), .SPI_START(start[0]), .SPI_DONE(done[0]),
    .SPI_VALUE(val[0]), .PWM_DUTY(duty[0]), .SAMPLE_VALID(valid[0]), .OVERRUN(ovr[0]),
    .TIMEOUT_ERR(terr[0])
  );

  mic_sample_sequencer #(.SAMPLE_DIV(64), .AVG_LOG2(0)) u_raw (
    .CLK(clk), .RST(rst[1]), .ENABLE(en[1]), .SPI_START(start[1]), .SPI_DONE(done[1]),
    .SPI_VALUE(val[1]), .PWM_DUTY(duty[1]), .SAMPLE_VALID(valid[1]), .OVERRUN(ovr[1]),
    .TIMEOUT_ERR(terr[1])
  );

  mic_sample_sequencer #(.SAMPLE_DIV(1024), .TIMEOUT(4096)) u_slow (
    .CLK(clk), .RST(rst[2]), .ENABLE(en[2]), .SPI_START(start[2]), .SPI_DONE(done[2]),
    .SPI_VALUE(val[2]), .PWM_DUTY(duty[2]), .SAMPLE_VALID(valid[2]), .OVERRUN(ovr[2]),
    .TIMEOUT_ERR(terr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns the number of falling edges until SPI_START is seen high, or -1.
  task automatic wait_start(input int k, input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (start[k]) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int k, input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (valid[k]) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Called at the falling edge where START was first seen; DONE is sampled
  // 'delay' rising edges later. Returns at the falling edge after that.
  task automatic convert(input int k, input int delay, input logic [15:0] v);
    repeat (delay - 1) @(negedge clk);
    done[k] = 1'b1;
    val[k]  = v;
    @(negedge clk);
    done[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst  = 3'b000;
    en   = 3'b000;
    done = 3'b000;
    for (int k = 0; k < 3; k++) val[k] = 16'h0000;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({start[k], valid[k], ovr[k], terr[k], duty[k]} !== 15'h0000) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %b/%b/%b/%b/%h expected all zero", k, start[k],
                 valid[k], ovr[k], terr[k], duty[k]);
      end
    end
  endtask

  task automatic test_average;
    logic [10:0] exp_duty [4];
    exp_duty = '{11'h1FF, 11'h3FF, 11'h5FF, 11'h7FF};
    rst[0] = 1'b1;
    en[0]  = 1'b1;
    // Tick at count 2267, pending on the next edge, then REQ, then START.
    wait_start(0, 3000, n);
    n_checks++;
    if (n !== 2270) begin
      n_fail++;
      $display("FAIL first_start: got %0d edges expected 2270", n);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        // One slot (2268) minus the 43 edges spent serving the previous sample.
        wait_start(0, 2400, n);
        n_checks++;
        if (n !== 2225) begin
          n_fail++;
          $display("FAIL slot_start[%0d]: got %0d edges expected 2225", i, n);
        end
      end
      convert(0, 40, 16'h0FFF);
      n_checks++;
      if (start[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL start_drop[%0d]: got %b expected 0", i, start[0]);
      end
      wait_valid(0, 10, n);
      n_checks++;
      if (n !== 2) begin
        n_fail++;
        $display("FAIL valid_latency[%0d]: got %0d expected 2", i, n);
      end
      n_checks++;
      if (duty[0] !== exp_duty[i]) begin
        n_fail++;
        $display("FAIL avg_duty[%0d]: got %h expected %h", i, duty[0], exp_duty[i]);
      end
      @(negedge clk);
      n_checks++;
      if (valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_pulse[%0d]: got %b expected 0", i, valid[0]);
      end
    end
  endtask

  task automatic test_timeout;
    bit saw_valid;
    wait_start(0, 2400, n);
    n_checks++;
    if (n !== 2225) begin
      n_fail++;
      $display("FAIL timeout_start: got %0d edges expected 2225", n);
    end
    saw_valid = 1'b0;
    n = -1;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (valid[0]) saw_valid = 1'b1;
      if (!start[0]) begin
        n = i;
        break;
      end
    end
    n_checks++;
    if (n !== 1024) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d expected 1024", n);
    end
    n_checks++;
    if (terr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got %b expected 1", terr[0]);
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_no_valid: got %b expected 0", saw_valid);
    end
    n_checks++;
    if (duty[0] !== 11'h7FF) begin
      n_fail++;
      $display("FAIL timeout_duty_hold: got %h expected 7ff", duty[0]);
    end
    // Next slot boundary is 2268 edges after the abandoned START rose.
    wait_start(0, 1400, n);
    n_checks++;
    if (n !== 1244) begin
      n_fail++;
      $display("FAIL restart_after_timeout: got %0d expected 1244", n);
    end
  endtask

  task automatic test_reset_mid_conversion;
    repeat (10) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({start[0], valid[0], ovr[0], terr[0], duty[0]} !== 15'h0000) begin
      n_fail++;
      $display("FAIL mid_reset: got %b/%b/%b/%b/%h expected all zero", start[0], valid[0],
               ovr[0], terr[0], duty[0]);
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    wait_start(0, 3000, n);
    n_checks++;
    if (n !== 2270) begin
      n_fail++;
      $display("FAIL mid_reset_start: got %0d expected 2270", n);
    end
    convert(0, 40, 16'h0FFF);
    wait_valid(0, 10, n);
    n_checks++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL mid_reset_latency: got %0d expected 2", n);
    end
    n_checks++;
    if (duty[0] !== 11'h1FF) begin
      n_fail++;
      $display("FAIL avg_restart: got %h expected 1ff", duty[0]);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_raw_and_enable;
    rst[1] = 1'b1;
    en[1]  = 1'b1;
    wait_start(1, 200, n);
    n_checks++;
    if (n !== 66) begin
      n_fail++;
      $display("FAIL raw_first_start: got %0d expected 66", n);
    end
    convert(1, 5, 16'h0ABC);
    wait_valid(1, 10, n);
    n_checks++;
    if (n !== 2 || duty[1] !== 11'h55E) begin
      n_fail++;
      $display("FAIL raw_sample0: got latency %0d duty %h expected 2 / 55e", n, duty[1]);
    end
    wait_start(1, 100, n);
    n_checks++;
    if (n !== 57) begin
      n_fail++;
      $display("FAIL raw_second_start: got %0d expected 57", n);
    end
    // Dropping ENABLE mid-conversion must still let this sample through.
    en[1] = 1'b0;
    convert(1, 5, 16'hF123);
    wait_valid(1, 10, n);
    n_checks++;
    if (n !== 2 || duty[1] !== 11'h091) begin
      n_fail++;
      $display("FAIL raw_sample1: got latency %0d duty %h expected 2 / 091", n, duty[1]);
    end
    wait_start(1, 200, n);
    n_checks++;
    if (n !== -1) begin
      n_fail++;
      $display("FAIL disabled_no_start: got start after %0d edges expected none", n);
    end
  endtask

  task automatic test_done_held;
    bit bad;
    en[1]   = 1'b1;
    done[1] = 1'b1;
    val[1]  = 16'h0002;
    bad     = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (start[1]) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_done_blocks: got start=1 expected 0 while DONE high");
    end
    done[1] = 1'b0;
    wait_start(1, 10, n);
    n_checks++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL start_after_done_low: got %0d expected 2", n);
    end
    convert(1, 3, 16'h0002);
    wait_valid(1, 10, n);
    n_checks++;
    if (n !== 2 || duty[1] !== 11'h001) begin
      n_fail++;
      $display("FAIL held_sample: got latency %0d duty %h expected 2 / 001", n, duty[1]);
    end
    en[1] = 1'b0;
    n_checks++;
    if (ovr[1] !== 1'b0 || terr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_flags: got ovr %b terr %b expected 0 0", ovr[1], terr[1]);
    end
  endtask

  task automatic test_overrun;
    rst[2] = 1'b1;
    en[2]  = 1'b1;
    wait_start(2, 1100, n);
    n_checks++;
    if (n !== 1026) begin
      n_fail++;
      $display("FAIL slow_first_start: got %0d expected 1026", n);
    end
    for (int i = 1; i <= 2299; i++) begin
      @(negedge clk);
      if (i == 1100) begin
        n_checks++;
        if (ovr[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL queued_no_overrun: got %b expected 0", ovr[2]);
        end
      end
      if (i == 2100) begin
        n_checks++;
        if (ovr[2] !== 1'b1) begin
          n_fail++;
          $display("FAIL second_tick_overrun: got %b expected 1", ovr[2]);
        end
      end
    end
    done[2] = 1'b1;
    val[2]  = 16'h0800;
    @(negedge clk);
    done[2] = 1'b0;
    wait_valid(2, 10, n);
    n_checks++;
    if (n !== 2 || duty[2] !== 11'h100) begin
      n_fail++;
      $display("FAIL slow_sample: got latency %0d duty %h expected 2 / 100", n, duty[2]);
    end
    n_checks++;
    if (terr[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_no_timeout: got %b expected 0", terr[2]);
    end
    wait_start(2, 10, n);
    n_checks++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL queued_restart: got %0d expected 2", n);
    end
    en[2] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_average();
    test_timeout();
    test_reset_mid_conversion();
    test_raw_and_enable();
    test_done_held();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
